// File: rtl/spi_shift_engine.sv
// SPI master bit engine: shifts one DATA_W-bit word full-duplex (MSB first).
// SCLK timing comes from the half-period ticks of the divider output sck_i, used here as data only.
module spi_shift_engine #(
    parameter int DATA_W      = 8,
    parameter int CS_SETUP_HP = 1,
    parameter int CS_HOLD_HP  = 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              sck_i,
    input  logic              start_i,
    input  logic              cpol_i,
    input  logic              cpha_i,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              miso_i,
    output logic              sclk_o,
    output logic              mosi_o,
    output logic              cs_n_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] rx_data_o
);

    localparam int HP_MAX = (CS_SETUP_HP > CS_HOLD_HP) ? CS_SETUP_HP : CS_HOLD_HP;
    localparam int HP_W   = $clog2(HP_MAX + 1);
    localparam int EDGE_W = $clog2(2 * DATA_W);

    localparam logic [HP_W-1:0]   SETUP_LAST = HP_W'(CS_SETUP_HP - 1);
    localparam logic [HP_W-1:0]   HOLD_LAST  = HP_W'(CS_HOLD_HP - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST  = EDGE_W'(2 * DATA_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_XFER,
        ST_HOLD
    } state_t;

    state_t              state_q, state_d;
    logic                sck_dly_q, sck_dly_d;
    logic [HP_W-1:0]     hp_cnt_q, hp_cnt_d;
    logic [EDGE_W-1:0]   edge_cnt_q, edge_cnt_d;
    logic                sclk_q, sclk_d;
    logic                mosi_q, mosi_d;
    logic                cs_n_q, cs_n_d;
    logic                done_q, done_d;
    logic [DATA_W-1:0]   rx_q, rx_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                cpol_q, cpol_d;
    logic                cpha_q, cpha_d;
    logic                tick;

    // One tick per sck_i half-period, detected as a change against last cycle's value.
    assign tick = sck_i ^ sck_dly_q;

    always_comb begin
        state_d    = state_q;
        sck_dly_d  = sck_i;
        hp_cnt_d   = hp_cnt_q;
        edge_cnt_d = edge_cnt_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        cs_n_d     = cs_n_q;
        done_d     = 1'b0;
        rx_d       = rx_q;
        shift_d    = shift_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;

        case (state_q)
            ST_IDLE: begin
                sclk_d = cpol_i;
                if (start_i) begin
                    cpol_d   = cpol_i;
                    cpha_d   = cpha_i;
                    shift_d  = tx_data_i;
                    cs_n_d   = 1'b0;
                    mosi_d   = cpha_i ? 1'b0 : tx_data_i[DATA_W-1];
                    hp_cnt_d = '0;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                sclk_d = cpol_q;
                if (tick) begin
                    if (hp_cnt_q == SETUP_LAST) begin
                        edge_cnt_d = '0;
                        state_d    = ST_XFER;
                    end else begin
                        hp_cnt_d = hp_cnt_q + 1'b1;
                    end
                end
            end
            ST_XFER: begin
                if (tick) begin
                    sclk_d     = ~sclk_q;
                    edge_cnt_d = edge_cnt_q + 1'b1;
                    // Sampling edges are the even ones for cpha=0 and the odd ones for cpha=1.
                    if (edge_cnt_q[0] == cpha_q) begin
                        shift_d = {shift_q[DATA_W-2:0], miso_i};
                    end else if (edge_cnt_q != EDGE_LAST) begin
                        mosi_d = shift_q[DATA_W-1];
                    end
                    if (edge_cnt_q == EDGE_LAST) begin
                        hp_cnt_d = '0;
                        state_d  = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                sclk_d = cpol_q;
                if (tick) begin
                    if (hp_cnt_q == HOLD_LAST) begin
                        cs_n_d  = 1'b1;
                        rx_d    = shift_q;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        hp_cnt_d = hp_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            sck_dly_q  <= 1'b0;
            hp_cnt_q   <= '0;
            edge_cnt_q <= '0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            done_q     <= 1'b0;
            rx_q       <= '0;
        end else begin
            state_q    <= state_d;
            sck_dly_q  <= sck_dly_d;
            hp_cnt_q   <= hp_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            cs_n_q     <= cs_n_d;
            done_q     <= done_d;
            rx_q       <= rx_d;
        end
    end

    // Shift word and latched mode bits are only meaningful once a start has loaded them.
    always_ff @(posedge clk_i) begin
        shift_q <= shift_d;
        cpol_q  <= cpol_d;
        cpha_q  <= cpha_d;
    end

    assign sclk_o    = sclk_q;
    assign mosi_o    = mosi_q;
    assign cs_n_o    = cs_n_q;
    assign busy_o    = (state_q != ST_IDLE);
    assign done_o    = done_q;
    assign rx_data_o = rx_q;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Bench for spi_shift_engine: divider and slave models, a tick-counting reference model
// compared every cycle, directed scenarios with literal expectations, then random transfers.
module tb_spi_shift_engine;

    localparam int W     = 8;
    localparam int SHP   = 1;
    localparam int HHP   = 1;
    localparam int TOTAL = SHP + 2 * W + HHP;

    logic         clk = 1'b0;
    logic         reset_i, sck_i, start_i, cpol_i, cpha_i, miso_i;
    logic [W-1:0] tx_data_i;
    logic         sclk_o, mosi_o, cs_n_o, busy_o, done_o;
    logic [W-1:0] rx_data_o;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    spi_shift_engine #(.DATA_W(W), .CS_SETUP_HP(SHP), .CS_HOLD_HP(HHP)) dut (
        .clk_i(clk), .reset_i(reset_i), .sck_i(sck_i), .start_i(start_i),
        .cpol_i(cpol_i), .cpha_i(cpha_i), .tx_data_i(tx_data_i), .miso_i(miso_i),
        .sclk_o(sclk_o), .mosi_o(mosi_o), .cs_n_o(cs_n_o), .busy_o(busy_o),
        .done_o(done_o), .rx_data_o(rx_data_o)
    );

    // Divider stand-in: sck toggles every div_d+1 cycles.
    int   div_d = 1;
    int   div_cnt = 0;
    logic sck_r = 1'b0;
    always @(posedge clk) begin
        if (div_cnt >= div_d) begin
            div_cnt <= 0;
            sck_r   <= ~sck_r;
        end else begin
            div_cnt <= div_cnt + 1;
        end
    end
    assign sck_i = sck_r;

    // miso source: 0 = bench value, 1 = loopback of mosi, 2 = slave shifting on rising SCLK.
    int           miso_sel = 0;
    logic         miso_r = 1'b0;
    logic         slave_miso = 1'b0;
    logic [W-1:0] slave_word = '0;
    int           slave_idx = W - 1;
    logic         sclk_prev_s = 1'b0;
    always @(posedge clk) begin
        sclk_prev_s <= sclk_o;
        if (cs_n_o !== 1'b0) begin
            slave_idx  <= W - 1;
            slave_miso <= 1'b0;
        end else if (sclk_o && !sclk_prev_s) begin
            slave_miso <= slave_word[slave_idx];
            slave_idx  <= slave_idx - 1;
        end
    end
    assign miso_i = (miso_sel == 1) ? mosi_o : (miso_sel == 2) ? slave_miso : miso_r;

    // Reference model: counts ticks since start and derives every output from that count.
    logic         m_act = 1'b0, m_cpol = 1'b0, m_cpha = 1'b0, m_prev = 1'b0, m_tick;
    int           m_n = 0, m_edges = 0, m_k;
    logic [W-1:0] m_tx = '0, m_acc = '0;
    logic         e_cs_n = 1'b1, e_sclk = 1'b0, e_mosi = 1'b0, e_done = 1'b0;
    logic [W-1:0] e_rx = '0;

    initial forever begin
        @(posedge clk);
        if (reset_i) begin
            m_act = 1'b0; e_cs_n = 1'b1; e_sclk = 1'b0; e_mosi = 1'b0;
            e_done = 1'b0; e_rx = '0; m_prev = 1'b0;
        end else begin
            m_tick = sck_i ^ m_prev;
            m_prev = sck_i;
            e_done = 1'b0;
            if (!m_act) begin
                e_sclk = cpol_i;
                if (start_i) begin
                    m_act = 1'b1; m_n = 0; m_cpol = cpol_i; m_cpha = cpha_i;
                    m_tx = tx_data_i; m_acc = '0; e_cs_n = 1'b0;
                    e_mosi = cpha_i ? 1'b0 : tx_data_i[W-1];
                end
            end else if (m_tick) begin
                if (m_n >= SHP && m_n < SHP + 2 * W && ((m_n - SHP) % 2) == int'(m_cpha))
                    m_acc = {m_acc[W-2:0], miso_i};
                m_n++;
                m_edges = m_n - SHP;
                if (m_edges < 0) m_edges = 0;
                if (m_edges > 2 * W) m_edges = 2 * W;
                e_sclk = m_cpol ^ (m_edges % 2 == 1);
                if (!m_cpha) begin
                    m_k = m_edges / 2;
                    if (m_k > W - 1) m_k = W - 1;
                    e_mosi = m_tx[W-1-m_k];
                end else if (m_edges > 0) begin
                    e_mosi = m_tx[W-1-((m_edges-1)/2)];
                end
                if (m_n == TOTAL) begin
                    m_act = 1'b0; e_cs_n = 1'b1; e_done = 1'b1; e_rx = m_acc;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (done_o === 1'b1) done_cnt++;
        if (chk_en) begin
            chk("cs_n", 32'(cs_n_o), 32'(e_cs_n));
            chk("sclk", 32'(sclk_o), 32'(e_sclk));
            chk("mosi", 32'(mosi_o), 32'(e_mosi));
            chk("busy", 32'(busy_o), 32'(m_act));
            chk("done", 32'(done_o), 32'(e_done));
            chk("rx",   32'(rx_data_o), 32'(e_rx));
        end
    end

    // Called at a negedge; start is sampled on the next posedge.
    task automatic start_xfer(input logic cp, input logic ph, input logic [W-1:0] tx);
        cpol_i = cp; cpha_i = ph; tx_data_i = tx; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic watch(output logic [W-1:0] rx, output int cyc, output int rises,
                         output int csn_hi, output logic [W-1:0] fall_bits);
        logic prev;
        prev = sclk_o; cyc = 0; rises = 0; csn_hi = 0; fall_bits = '0;
        while (done_o !== 1'b1 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (sclk_o && !prev) rises++;
            if (!sclk_o && prev) fall_bits = {fall_bits[W-2:0], mosi_o};
            if (cs_n_o && !done_o) csn_hi++;
            prev = sclk_o;
        end
        if (done_o !== 1'b1) begin
            checks++; failures++;
            $display("FAIL done_timeout actual=no_done required=done t=%0t", $time);
        end
        rx = rx_data_o;
    endtask

    logic [W-1:0] rx, rx2, fb;
    int           cyc, rises, csn_hi, d0, tog, lim;
    logic         prev_s, csn_at_done;

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset_i = 1'b1; start_i = 1'b0; cpol_i = 1'b0; cpha_i = 1'b0; tx_data_i = '0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_cs_n", 32'(cs_n_o), 32'd1);
        chk("rst_sclk", 32'(sclk_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_rx",   32'(rx_data_o), 32'd0);
        reset_i = 1'b0;
        repeat (3) @(negedge clk);

        // 1: mode 0, D=1, loopback 0xA5
        miso_sel = 1; div_d = 1;
        d0 = done_cnt;
        start_xfer(1'b0, 1'b0, 8'hA5);
        watch(rx, cyc, rises, csn_hi, fb);
        chk("t1_rx", 32'(rx), 32'hA5);
        chk("t1_rises", 32'(rises), 32'd8);
        chk("t1_csn_low", 32'(csn_hi), 32'd0);
        chk("t1_latency_ok", 32'(cyc >= 34 && cyc <= 40), 32'd1);
        repeat (3) @(negedge clk);
        chk("t1_one_done", 32'(done_cnt - d0), 32'd1);

        // 2: mode 3, miso tied 1, tx 0x3C
        miso_sel = 0; miso_r = 1'b1; cpol_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("t2_idle_high", 32'(sclk_o), 32'd1);
        start_xfer(1'b1, 1'b1, 8'h3C);
        watch(rx, cyc, rises, csn_hi, fb);
        chk("t2_rx", 32'(rx), 32'hFF);
        chk("t2_mosi_on_falls", 32'(fb), 32'h3C);
        repeat (2) @(negedge clk);
        chk("t2_idle_high_after", 32'(sclk_o), 32'd1);

        // 3: mode 1, slave shifts 0x96 on rising edges
        miso_sel = 2; slave_word = 8'h96; div_d = 2; cpol_i = 1'b0;
        repeat (3) @(negedge clk);
        start_xfer(1'b0, 1'b1, 8'h00);
        watch(rx, cyc, rises, csn_hi, fb);
        chk("t3_rx", 32'(rx), 32'h96);

        // 4: second start mid-XFER is ignored
        miso_sel = 1; div_d = 1;
        repeat (2) @(negedge clk);
        d0 = done_cnt;
        start_xfer(1'b0, 1'b0, 8'h5A);
        repeat (12) @(negedge clk);
        start_xfer(1'b1, 1'b1, 8'h00);
        watch(rx, cyc, rises, csn_hi, fb);
        chk("t4_rx", 32'(rx), 32'h5A);
        chk("t4_csn_low", 32'(csn_hi), 32'd0);
        csn_hi = 0;
        repeat (10) begin
            @(negedge clk);
            if (!cs_n_o || busy_o) csn_hi++;
        end
        chk("t4_no_extra_xfer", 32'(csn_hi), 32'd0);
        chk("t4_one_done", 32'(done_cnt - d0), 32'd1);

        // 5: reset at edge_cnt=7
        start_xfer(1'b0, 1'b0, 8'hF0);
        prev_s = sclk_o; tog = 0; lim = 0;
        while (tog < 7 && lim < 500) begin
            @(negedge clk);
            lim++;
            if (sclk_o != prev_s) tog++;
            prev_s = sclk_o;
        end
        chk("t5_reached_edge7", 32'(tog), 32'd7);
        d0 = done_cnt;
        reset_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
        chk("t5_cs_n", 32'(cs_n_o), 32'd1);
        chk("t5_busy", 32'(busy_o), 32'd0);
        chk("t5_sclk", 32'(sclk_o), 32'd0);
        chk("t5_rx",   32'(rx_data_o), 32'd0);
        repeat (40) @(negedge clk);
        chk("t5_no_done", 32'(done_cnt - d0), 32'd0);
        start_xfer(1'b0, 1'b0, 8'hC3);
        watch(rx, cyc, rises, csn_hi, fb);
        chk("t5_after_rx", 32'(rx), 32'hC3);

        // 6: D=0, back-to-back 0x01 then 0x80
        repeat (2) @(negedge clk);
        div_d = 0;
        repeat (2) @(negedge clk);
        start_xfer(1'b0, 1'b0, 8'h01);
        watch(rx, cyc, rises, csn_hi, fb);
        csn_at_done = cs_n_o;
        start_xfer(1'b0, 1'b0, 8'h80);
        watch(rx2, cyc, rises, csn_hi, fb);
        chk("t6_rx1", 32'(rx), 32'h01);
        chk("t6_rx2", 32'(rx2), 32'h80);
        chk("t6_csn_gap", 32'(csn_at_done), 32'd1);

        // Random transfers against the model, with ignored starts and random miso
        miso_sel = 0;
        for (int i = 0; i < 24; i++) begin
            div_d = int'($urandom_range(0, 3));
            start_xfer(1'($urandom), 1'($urandom), 8'($urandom));
            lim = 0;
            forever begin
                @(negedge clk);
                lim++;
                if (done_o === 1'b1 || lim > 3000) break;
                miso_r    = 1'($urandom);
                start_i   = ($urandom_range(0, 15) == 0);
                tx_data_i = 8'($urandom);
                cpha_i    = 1'($urandom);
            end
            start_i = 1'b0;
            chk("rand_done_seen", 32'(done_o), 32'd1);
            if (i % 3 != 0) repeat ($urandom_range(1, 5)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
